// File: rtl/pipe_io_pkg.sv
// Shared constants for the MEM-stage I/O window: register offsets, TCTL bit
// positions and the port-count ceiling.
package pipe_io_pkg;
  localparam int IO_ADDR_W = 8;
  localparam int MAX_PORTS = 16;
  localparam int IDX_W     = $clog2(MAX_PORTS);

  localparam logic [IO_ADDR_W-1:0] IN_BASE  = 8'h00;
  localparam logic [IO_ADDR_W-1:0] OUT_BASE = 8'h40;
  localparam logic [IO_ADDR_W-1:0] CHG_OFS  = 8'h80;
  localparam logic [IO_ADDR_W-1:0] MASK_OFS = 8'h84;
  localparam logic [IO_ADDR_W-1:0] TCNT_OFS = 8'h88;
  localparam logic [IO_ADDR_W-1:0] TCMP_OFS = 8'h8C;
  localparam logic [IO_ADDR_W-1:0] TCTL_OFS = 8'h90;

  localparam int TCTL_EN    = 0;
  localparam int TCTL_AR    = 1;
  localparam int TCTL_MATCH = 2;
endpackage

// File: rtl/pipe_io_if.sv
// Single-cycle read/write bus between the MEM stage (master) and the I/O
// controller (slave); io_rdata is combinational.
interface pipe_io_if
  import pipe_io_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                 io_sel;
  logic                 io_we;
  logic                 io_re;
  logic [IO_ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0]    io_wdata;
  logic [DATA_W-1:0]    io_rdata;

  modport master (output io_sel, io_we, io_re, io_addr, io_wdata, input io_rdata);
  modport slave  (input io_sel, io_we, io_re, io_addr, io_wdata, output io_rdata);
endinterface

// File: rtl/pipe_io_sync.sv
// Two-flop input synchroniser followed by a previous-value flop; chg_o pulses
// for one cycle whenever the synchronised value moves.
module pipe_io_sync #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o,
  output logic              chg_o
);
  logic [DATA_W-1:0] s1_q, s2_q, prev_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign q_o   = s2_q;
  assign chg_o = (s2_q != prev_q);
endmodule

// File: rtl/pipe_io_ctrl.sv
// Memory-mapped I/O controller: N_IN synchronised inputs with sticky change
// flags, N_OUT output registers, masked interrupt; compare timer under PIPE_IO_TIMER_EN.
module pipe_io_ctrl
  import pipe_io_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  pipe_io_if.slave                bus,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  output logic                    io_irq
);
  logic [N_IN-1:0][DATA_W-1:0]  in_sync;
  logic [N_IN-1:0]              chg_pulse;
  logic [N_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [N_IN-1:0]              chg_q, chg_d, mask_q, mask_d;

  logic                 wr, rd, in_bank, out_bank;
  logic [IO_ADDR_W-1:0] a_w;
  logic [IDX_W-1:0]     idx;

  assign wr       = bus.io_sel & bus.io_we;
  assign rd       = bus.io_sel & bus.io_re;
  assign a_w      = {bus.io_addr[IO_ADDR_W-1:2], 2'b00};
  assign idx      = bus.io_addr[IDX_W+1:2];
  assign in_bank  = (a_w[7:6] == IN_BASE[7:6]);
  assign out_bank = (a_w[7:6] == OUT_BASE[7:6]);

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_sync
    pipe_io_sync #(.DATA_W(DATA_W)) u_sync (
      .clock  (clock),
      .resetn (resetn),
      .d_i    (in_port[gi*DATA_W +: DATA_W]),
      .q_o    (in_sync[gi]),
      .chg_o  (chg_pulse[gi])
    );
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    if (wr && out_bank)
      for (int i = 0; i < N_OUT; i++)
        if (idx == IDX_W'(i)) out_d[i] = bus.io_wdata;
    if (wr && a_w == MASK_OFS) mask_d = N_IN'(bus.io_wdata);
    // A fresh change on the clearing edge must survive, so OR the pulse in last.
    chg_d = ((rd && a_w == CHG_OFS) ? '0 : chg_q) | chg_pulse;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_q  <= '0;
      chg_q  <= '0;
      mask_q <= '0;
    end else begin
      out_q  <= out_d;
      chg_q  <= chg_d;
      mask_q <= mask_d;
    end
  end

  assign out_port = out_q;

`ifdef PIPE_IO_TIMER_EN
  logic [DATA_W-1:0] tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic [2:0]        tctl_q, tctl_d;
  logic              match_set, ctl_wr;

  assign match_set = tctl_q[TCTL_EN] && (tcnt_q == tcmp_q);
  assign ctl_wr    = wr && (a_w == TCTL_OFS);

  always_comb begin
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    tctl_d = tctl_q;
    if (match_set)
      tcnt_d = tctl_q[TCTL_AR] ? '0 : tcnt_q + DATA_W'(1);
    else if (tctl_q[TCTL_EN])
      tcnt_d = tcnt_q + DATA_W'(1);
    if (wr && a_w == TCNT_OFS) tcnt_d = bus.io_wdata;
    if (wr && a_w == TCMP_OFS) tcmp_d = bus.io_wdata;
    if (ctl_wr) begin
      tctl_d[TCTL_EN] = bus.io_wdata[TCTL_EN];
      tctl_d[TCTL_AR] = bus.io_wdata[TCTL_AR];
    end
    tctl_d[TCTL_MATCH] = (tctl_q[TCTL_MATCH] & ~(ctl_wr & bus.io_wdata[TCTL_MATCH])) | match_set;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tcnt_q <= '0;
      tcmp_q <= '0;
      tctl_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      tctl_q <= tctl_d;
    end
  end

  assign io_irq = (|(chg_q & mask_q)) | (tctl_q[TCTL_MATCH] & tctl_q[TCTL_EN]);
`else
  assign io_irq = |(chg_q & mask_q);
`endif

  always_comb begin
    bus.io_rdata = '0;
    if (in_bank)
      for (int i = 0; i < N_IN; i++)
        if (idx == IDX_W'(i)) bus.io_rdata = in_sync[i];
    if (out_bank)
      for (int i = 0; i < N_OUT; i++)
        if (idx == IDX_W'(i)) bus.io_rdata = out_q[i];
    case (a_w)
      CHG_OFS:  bus.io_rdata = DATA_W'(chg_q);
      MASK_OFS: bus.io_rdata = DATA_W'(mask_q);
`ifdef PIPE_IO_TIMER_EN
      TCNT_OFS: bus.io_rdata = tcnt_q;
      TCMP_OFS: bus.io_rdata = tcmp_q;
      TCTL_OFS: bus.io_rdata = DATA_W'(tctl_q);
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pipe_io_ctrl.sv
// Directed bench for pipe_io_ctrl (DATA_W=32, N_IN=2, N_OUT=2) with a
// scoreboard queue of expected values; the timer part follows PIPE_IO_TIMER_EN.
module tb_pipe_io_ctrl;
  localparam int DATA_W = 32;
  localparam int N_IN   = 2;
  localparam int N_OUT  = 2;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic                    clock = 1'b0;
  logic                    resetn;
  logic [N_IN*DATA_W-1:0]  in_port;
  logic [N_OUT*DATA_W-1:0] out_port;
  logic                    io_irq;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_io_if #(.DATA_W(DATA_W)) bus ();

  pipe_io_ctrl #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .io_irq   (io_irq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got %h, expected nothing queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    check(obs);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.io_sel   = 1'b1;
    bus.io_we    = 1'b1;
    bus.io_addr  = a;
    bus.io_wdata = d;
    tick();
    bus.io_sel   = 1'b0;
    bus.io_we    = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string tag);
    bus.io_sel  = 1'b0;
    bus.io_re   = 1'b0;
    bus.io_addr = a;
    push(tag, exp);
    #1;
    check(bus.io_rdata);
  endtask

  task automatic rd_clr(input logic [7:0] a, input logic [31:0] exp, input string tag);
    bus.io_sel  = 1'b1;
    bus.io_re   = 1'b1;
    bus.io_addr = a;
    push(tag, exp);
    #1;
    check(bus.io_rdata);
    tick();
    bus.io_sel  = 1'b0;
    bus.io_re   = 1'b0;
  endtask

  initial begin
    resetn       = 1'b0;
    in_port      = '0;
    bus.io_sel   = 1'b0;
    bus.io_we    = 1'b0;
    bus.io_re    = 1'b0;
    bus.io_addr  = '0;
    bus.io_wdata = '0;
    tick();
    tick();
    resetn = 1'b1;

    // reset state
    chk("rst_out_lo", out_port[31:0], 32'h0);
    chk("rst_out_hi", out_port[63:32], 32'h0);
    chk("rst_irq", {31'h0, io_irq}, 32'h0);
    for (int a = 0; a < 256; a += 4) peek(8'(a), 32'h0, "rst_rd");

    // output registers, RO and unmapped writes
    wr(8'h44, 32'hDEADBEEF);
    chk("out1_port", out_port[63:32], 32'hDEADBEEF);
    chk("out0_untouched", out_port[31:0], 32'h0);
    peek(8'h44, 32'hDEADBEEF, "out1_rd");
    wr(8'h41, 32'h12345678);
    chk("out0_port", out_port[31:0], 32'h12345678);
    peek(8'h42, 32'h12345678, "out0_rd_lowbits");
    wr(8'h00, 32'hFFFFFFFF);
    peek(8'h00, 32'h0, "ro_in0_write");
    wr(8'h48, 32'hFFFFFFFF);
    peek(8'h48, 32'h0, "unmapped_out2");
    wr(8'h80, 32'hFFFFFFFF);
    peek(8'h80, 32'h0, "ro_chg_write");

    // input change detect
    in_port[31:0] = 32'h5;
    tick();
    peek(8'h00, 32'h0, "in0_after1");
    tick();
    peek(8'h00, 32'h5, "in0_after2");
    peek(8'h80, 32'h0, "chg_after2");
    tick();
    peek(8'h80, 32'h1, "chg_after3");
    chk("irq_masked", {31'h0, io_irq}, 32'h0);
    wr(8'h84, 32'h1);
    chk("irq_mask1", {31'h0, io_irq}, 32'h1);
    rd_clr(8'h80, 32'h1, "chg_rd");
    peek(8'h80, 32'h0, "chg_cleared");
    chk("irq_cleared", {31'h0, io_irq}, 32'h0);

    // set-wins race: bit1 sets on the edge that clears
    in_port[31:0] = 32'h6;
    tick();
    in_port[63:32] = 32'hA;
    tick();
    tick();
    rd_clr(8'h80, 32'h1, "race_rd_old");
    peek(8'h80, 32'h2, "race_bit1_kept");
    peek(8'h04, 32'hA, "in1_val");
    chk("irq_bit1_masked", {31'h0, io_irq}, 32'h0);
    wr(8'h84, 32'h3);
    chk("irq_bit1", {31'h0, io_irq}, 32'h1);
    rd_clr(8'h80, 32'h2, "chg_rd2");
    chk("irq_cleared2", {31'h0, io_irq}, 32'h0);

`ifdef PIPE_IO_TIMER_EN
    wr(8'h8C, 32'h3);
    wr(8'h90, 32'h3);
    peek(8'h88, 32'h0, "tcnt0");
    for (int n = 1; n <= 3; n++) begin
      tick();
      peek(8'h88, 32'(n), "tcnt_seq");
    end
    chk("tirq_at3", {31'h0, io_irq}, 32'h0);
    tick();
    peek(8'h88, 32'h0, "tcnt_reload");
    chk("tirq_match", {31'h0, io_irq}, 32'h1);
    peek(8'h90, 32'h7, "tctl_match");
    wr(8'h90, 32'h7);
    peek(8'h90, 32'h3, "tctl_cleared");
    chk("tirq_cleared", {31'h0, io_irq}, 32'h0);
    wr(8'h88, 32'd100);
    peek(8'h88, 32'd100, "tcnt_write_wins");
    wr(8'h90, 32'h0);
`else
    wr(8'h88, 32'hFF);
    peek(8'h88, 32'h0, "notimer_tcnt");
    wr(8'h90, 32'h7);
    peek(8'h90, 32'h0, "notimer_tctl");
    tick();
    chk("notimer_irq", {31'h0, io_irq}, 32'h0);
`endif

    // reset mid-operation discards flags and outputs
    wr(8'h84, 32'h1);
    in_port[31:0] = 32'h7;
    tick();
    tick();
    tick();
    chk("pre_rst_irq", {31'h0, io_irq}, 32'h1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mrst_out0", out_port[31:0], 32'h0);
    chk("mrst_irq", {31'h0, io_irq}, 32'h0);
    peek(8'h80, 32'h0, "mrst_chg");
    peek(8'h84, 32'h0, "mrst_mask");
    peek(8'h00, 32'h0, "mrst_in0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
